// File: rtl/dd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package dd_pkg;

    typedef enum logic [1:0] {
        DD_IDLE,
        DD_CONV,
        DD_DONE
    } dd_state_t;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd4;
    localparam logic [3:0]  BCD_ADJ_ADD    = 4'd3;

    // Smallest digit count d with 10**d >= 2**w.
    function automatic int dd_min_digits(input int w);
        longint unsigned lim;
        longint unsigned pw;
        int              d;
        lim = 64'd1 << w;
        pw  = 64'd1;
        d   = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            if (pw < lim) begin
                pw = pw * 64'd10;
                d  = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/dd_seq_ctrl_bcd_digit_adjust.sv
// Combinational add-3 stage: every BCD digit above 4 gets +3, others pass through.
module bcd_digit_adjust
    import dd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] digits_i,
    output logic [BCD_DIGIT_W*DIGITS-1:0] digits_o
);

    always_comb begin
        digits_o = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (digits_i[BCD_DIGIT_W*k +: BCD_DIGIT_W] > BCD_ADJ_THRESH) begin
                digits_o[BCD_DIGIT_W*k +: BCD_DIGIT_W] =
                    digits_i[BCD_DIGIT_W*k +: BCD_DIGIT_W] + BCD_ADJ_ADD;
            end else begin
                digits_o[BCD_DIGIT_W*k +: BCD_DIGIT_W] =
                    digits_i[BCD_DIGIT_W*k +: BCD_DIGIT_W];
            end
        end
    end

endmodule

// File: rtl/dd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// registered result with a one-cycle done pulse.
module dd_seq_ctrl
    import dd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [DATA_W-1:0]             i_bin,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (DIGITS < dd_min_digits(DATA_W)) begin : g_digits_check
        $error("dd_seq_ctrl: DIGITS too small to hold 2**DATA_W - 1");
    end

    dd_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0]  bin_q,   bin_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BCD_W-1:0]   res_q,   res_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+DATA_W-1:0] work_shifted;

    bcd_digit_adjust #(
        .DIGITS (DIGITS)
    ) u_adjust (
        .digits_i (bcd_q),
        .digits_o (bcd_adj)
    );

    always_comb begin
        work_shifted = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        res_d   = res_q;
        case (state_q)
            DD_IDLE, DD_DONE: begin
                // DONE accepts a new start directly so back-to-back runs skip IDLE.
                if (i_start) begin
                    state_d = DD_CONV;
                    bin_d   = i_bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    state_d = DD_IDLE;
                end
            end
            DD_CONV: begin
                bcd_d = work_shifted[BCD_W+DATA_W-1:DATA_W];
                bin_d = work_shifted[DATA_W-1:0];
                if (cnt_q == '0) begin
                    state_d = DD_DONE;
                    res_d   = work_shifted[BCD_W+DATA_W-1:DATA_W];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = DD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= DD_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            res_q   <= res_d;
        end
    end

    assign o_busy = (state_q == DD_CONV);
    assign o_done = (state_q == DD_DONE);
    assign o_bcd  = res_q;

endmodule

// File: tb/tb_dd_seq_ctrl.sv
// Directed and exhaustive self-checking bench for dd_seq_ctrl (DATA_W=8, DIGITS=3).
module tb_dd_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int total = 0;
    int bad   = 0;

    dd_seq_ctrl #(
        .DATA_W (8),
        .DIGITS (3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_bin   (bin),
        .o_busy  (busy),
        .o_done  (done),
        .o_bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (busy && done) begin
                bad++;
                $display("FAIL busy_done_excl: busy=%0b done=%0b required not both 1", busy, done);
            end
        end
    end

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic pulse_start(input logic [7:0] b);
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_n, output bit seen);
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        bin   = 8'd200;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (bcd !== 12'h000) begin bad++; $display("FAIL reset_bcd: got %h want 000", bcd); end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_255();
        int busy_n; bit seen;
        pulse_start(8'd255);
        wait_done(busy_n, seen);
        total++; if (!seen) begin bad++; $display("FAIL t2_done_seen: got 0 want 1"); end
        total++; if (busy_n != 8) begin bad++; $display("FAIL t2_busy_cycles: got %0d want 8", busy_n); end
        total++; if (bcd !== 12'h255) begin bad++; $display("FAIL t2_bcd: got %h want 255", bcd); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t2_done_pulse: got %b want 0", done); end
        total++; if (bcd !== 12'h255) begin bad++; $display("FAIL t2_bcd_hold: got %h want 255", bcd); end
    endtask

    task automatic test_values();
        logic [7:0]  vin [3] = '{8'd0, 8'd99, 8'd128};
        logic [11:0] vexp[3] = '{12'h000, 12'h099, 12'h128};
        int busy_n; bit seen;
        for (int i = 0; i < 3; i++) begin
            pulse_start(vin[i]);
            wait_done(busy_n, seen);
            total++; if (!seen || busy_n != 8) begin
                bad++; $display("FAIL t3_latency[%0d]: got busy=%0d seen=%0b want 8/1", i, busy_n, seen);
            end
            total++; if (bcd !== vexp[i]) begin
                bad++; $display("FAIL t3_bcd[%0d]: got %h want %h", i, bcd, vexp[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int busy_n = 0;
        int done_n = 0;
        logic [11:0] got = 'x;
        pulse_start(8'd200);
        // Now in CONV cycle 1; cycles counted from here.
        for (int i = 1; i <= 22; i++) begin
            if (i == 3) begin start = 1'b1; bin = 8'd17; end
            if (i == 4) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin done_n++; got = bcd; end
            @(negedge clk);
        end
        total++; if (busy_n != 8) begin bad++; $display("FAIL t4_busy: got %0d want 8", busy_n); end
        total++; if (done_n != 1) begin bad++; $display("FAIL t4_done_count: got %0d want 1", done_n); end
        total++; if (got !== 12'h200) begin bad++; $display("FAIL t4_bcd: got %h want 200", got); end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int idle_n = 0;
        logic [11:0] res[$];
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd45;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (!busy && !done) idle_n++;
            if (done) begin
                done_at.push_back(i);
                res.push_back(bcd);
                bin = 8'd46;
                if (done_at.size() == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        total++; if (done_at.size() != 2) begin
            bad++; $display("FAIL t5_done_count: got %0d want 2", done_at.size());
        end else begin
            total++; if (done_at[0] != 9 || done_at[1] != 18) begin
                bad++; $display("FAIL t5_done_spacing: got %0d,%0d want 9,18", done_at[0], done_at[1]);
            end
            total++; if (res[0] !== 12'h045 || res[1] !== 12'h046) begin
                bad++; $display("FAIL t5_bcd: got %h,%h want 045,046", res[0], res[1]);
            end
        end
        total++; if (idle_n != 0) begin bad++; $display("FAIL t5_idle_gap: got %0d want 0", idle_n); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_conv();
        int busy_n; bit seen;
        int done_n = 0;
        pulse_start(8'd255);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_busy_async: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t6_done_async: got %b want 0", done); end
        total++; if (bcd !== 12'h000) begin bad++; $display("FAIL t6_bcd_async: got %h want 000", bcd); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) done_n++;
        end
        total++; if (done_n != 0) begin bad++; $display("FAIL t6_no_done: got %0d want 0", done_n); end
        pulse_start(8'd7);
        wait_done(busy_n, seen);
        total++; if (!seen || bcd !== 12'h007) begin
            bad++; $display("FAIL t6_after_reset: got %h seen=%0b want 007", bcd, seen);
        end
    endtask

    task automatic test_exhaustive();
        int busy_n; bit seen;
        for (int v = 0; v < 256; v++) begin
            pulse_start(8'(v));
            wait_done(busy_n, seen);
            total++;
            if (!seen || busy_n != 8 || bcd !== ref_bcd(v)) begin
                bad++;
                $display("FAIL sweep[%0d]: got %h busy=%0d seen=%0b want %h", v, bcd, busy_n, seen, ref_bcd(v));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        test_reset();
        test_basic_255();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_conv();
        test_exhaustive();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
